sr_reg_bank: RTL and testbench

Parametrised bank of WIDTH independent SR storage channels with a common clock, enable and synchronous reset. The S=R=1 conflict resolution is selectable per instance. Each channel reports registered edge pulses and a conflict flag. A saturating conflict counter and a sticky error flag support status reporting. The bank sits in the flip-flop library as the general-purpose successor for set/reset status bits: interrupt pending bits, sticky fault latches and handshake flags.

---
 rtl/sr_reg_bank_pkg.sv | 34 +++
 rtl/sr_reg_bank_if.sv | 27 ++
 rtl/sr_reg_bank_sr_cell.sv | 56 +++++
 rtl/sr_reg_bank.sv | 82 ++++++++
 tb/tb_sr_reg_bank.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/sr_reg_bank_pkg.sv
// Shared types and next-state function for the SR register bank.
// The testbench also imports this package.
package sr_pkg;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        SET_DOM = 2'd1,
        RST_DOM = 2'd2,
        TOGGLE  = 2'd3
    } conflict_mode_e;

    // Next-state bit for one channel; S=R=1 is resolved by the instance policy
    function automatic logic sr_next(input logic q, input logic s, input logic r,
                                     input conflict_mode_e mode);
        logic nxt;
        case ({s, r})
            2'b00: nxt = q;
            2'b01: nxt = 1'b0;
            2'b10: nxt = 1'b1;
            2'b11: begin
                case (mode)
                    HOLD:    nxt = q;
                    SET_DOM: nxt = 1'b1;
                    RST_DOM: nxt = 1'b0;
                    TOGGLE:  nxt = ~q;
                    default: nxt = q;
                endcase
            end
            default: nxt = q;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/sr_reg_bank_if.sv
// Request/status bundle of the SR register bank.
// The master drives the requests; the bank (slave) drives the status.
interface sr_reg_bank_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             en;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr_cnt;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_rise;
    logic [WIDTH-1:0] q_fall;
    logic [WIDTH-1:0] conflict;
    logic [CNT_W-1:0] conflict_cnt;
    logic             err_sticky;

    modport master (
        output en, s, r, clr_cnt,
        input  q, q_rise, q_fall, conflict, conflict_cnt, err_sticky
    );

    modport slave (
        input  en, s, r, clr_cnt,
        output q, q_rise, q_fall, conflict, conflict_cnt, err_sticky
    );
endinterface

// File: rtl/sr_reg_bank_sr_cell.sv
// One SR storage channel: the q register plus its registered edge pulses
// and conflict flag.
module sr_cell
    import sr_pkg::*;
#(
    parameter conflict_mode_e CONFLICT_MODE = HOLD,
    parameter logic           RESET_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic s,
    input  logic r,
    output logic q,
    output logic q_rise,
    output logic q_fall,
    output logic conflict
);

    logic r_q;
    logic r_rise;
    logic r_fall;
    logic r_conflict;
    logic w_q_next;

    // Next q: the resolved request when enabled, otherwise hold
    always_comb begin
        w_q_next = r_q;
        if (en) begin
            w_q_next = sr_next(r_q, s, r, CONFLICT_MODE);
        end else begin
            w_q_next = r_q;
        end
    end

    // State and pulse registers; reset loads RESET_VAL without pulsing
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q        <= RESET_VAL;
            r_rise     <= 1'b0;
            r_fall     <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_q        <= w_q_next;
            r_rise     <= ~r_q & w_q_next;
            r_fall     <= r_q & ~w_q_next;
            r_conflict <= en & s & r;
        end
    end

    assign q        = r_q;
    assign q_rise   = r_rise;
    assign q_fall   = r_fall;
    assign conflict = r_conflict;

endmodule

// File: rtl/sr_reg_bank.sv
// Bank of WIDTH independent SR channels with a saturating conflict
// counter and a sticky conflict error flag.
module sr_reg_bank
    import sr_pkg::*;
#(
    parameter int             WIDTH         = 8,
    parameter conflict_mode_e CONFLICT_MODE = HOLD,
    parameter logic [WIDTH-1:0] RESET_VAL   = {WIDTH{1'b0}},
    parameter int             CNT_W         = 8
) (
    input  logic        clk,
    input  logic        rst,
    sr_reg_bank_if.slave bus
);

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("sr_reg_bank: WIDTH must be within 1..64");
    end
    if (CNT_W < 2 || CNT_W > 16) begin : g_bad_cnt_w
        $error("sr_reg_bank: CNT_W must be within 2..16");
    end
    if (int'(CONFLICT_MODE) > 3) begin : g_bad_mode
        $error("sr_reg_bank: CONFLICT_MODE must be within 0..3");
    end

    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_conflict;
    logic             w_any_conflict;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sticky;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_cell #(
            .CONFLICT_MODE (CONFLICT_MODE),
            .RESET_VAL     (RESET_VAL[i])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .en       (bus.en),
            .s        (bus.s[i]),
            .r        (bus.r[i]),
            .q        (w_q[i]),
            .q_rise   (w_rise[i]),
            .q_fall   (w_fall[i]),
            .conflict (w_conflict[i])
        );
    end

    // Counted once per cycle no matter how many channels collide
    assign w_any_conflict = bus.en & (|(bus.s & bus.r));

    // Saturating counter and sticky flag; clear beats a same-cycle conflict
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_sticky <= 1'b0;
        end else if (bus.clr_cnt) begin
            r_cnt    <= {CNT_W{1'b0}};
            r_sticky <= 1'b0;
        end else if (w_any_conflict) begin
            if (r_cnt != {CNT_W{1'b1}}) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= r_cnt;
            end
            r_sticky <= 1'b1;
        end else begin
            r_cnt    <= r_cnt;
            r_sticky <= r_sticky;
        end
    end

    assign bus.q            = w_q;
    assign bus.q_rise       = w_rise;
    assign bus.q_fall       = w_fall;
    assign bus.conflict     = w_conflict;
    assign bus.conflict_cnt = r_cnt;
    assign bus.err_sticky   = r_sticky;

endmodule

// File: tb/tb_sr_reg_bank.sv
// Directed bench: five banks (one per conflict mode, plus a 2-bit counter
// variant) share clock, reset and stimulus; expectations are hand-computed.
module tb_sr_reg_bank;
    import sr_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    sr_reg_bank_if #(.WIDTH(4), .CNT_W(8)) if0 ();
    sr_reg_bank_if #(.WIDTH(4), .CNT_W(8)) if1 ();
    sr_reg_bank_if #(.WIDTH(4), .CNT_W(8)) if2 ();
    sr_reg_bank_if #(.WIDTH(4), .CNT_W(8)) if3 ();
    sr_reg_bank_if #(.WIDTH(4), .CNT_W(2)) ifs ();

    sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(HOLD),    .RESET_VAL(4'b1010), .CNT_W(8))
        u0 (.clk(clk), .rst(rst), .bus(if0));
    sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(SET_DOM), .RESET_VAL(4'b1010), .CNT_W(8))
        u1 (.clk(clk), .rst(rst), .bus(if1));
    sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(RST_DOM), .RESET_VAL(4'b1010), .CNT_W(8))
        u2 (.clk(clk), .rst(rst), .bus(if2));
    sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(TOGGLE),  .RESET_VAL(4'b1010), .CNT_W(8))
        u3 (.clk(clk), .rst(rst), .bus(if3));
    sr_reg_bank #(.WIDTH(4), .CONFLICT_MODE(HOLD),    .RESET_VAL(4'b1010), .CNT_W(2))
        us (.clk(clk), .rst(rst), .bus(ifs));

    task automatic drive(input logic en_v, input logic [3:0] s_v, input logic [3:0] r_v,
                         input logic clr_v);
        if0.en = en_v; if0.s = s_v; if0.r = r_v; if0.clr_cnt = clr_v;
        if1.en = en_v; if1.s = s_v; if1.r = r_v; if1.clr_cnt = clr_v;
        if2.en = en_v; if2.s = s_v; if2.r = r_v; if2.clr_cnt = clr_v;
        if3.en = en_v; if3.s = s_v; if3.r = r_v; if3.clr_cnt = clr_v;
        ifs.en = en_v; ifs.s = s_v; ifs.r = r_v; ifs.clr_cnt = clr_v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [3:0] q1_e [3]  = '{4'b0001, 4'b0001, 4'b0001};
        logic [3:0] r1_e [3]  = '{4'b0001, 4'b0000, 4'b0000};
        logic [3:0] q3_e [3]  = '{4'b0001, 4'b0000, 4'b0001};
        logic [3:0] r3_e [3]  = '{4'b0001, 4'b0000, 4'b0001};
        logic [3:0] f3_e [3]  = '{4'b0000, 4'b0001, 4'b0000};
        logic [1:0] sat_e [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        logic [3:0] tg_e [5]  = '{4'b0000, 4'b0001, 4'b0000, 4'b0001, 4'b0000};

        // Reset held for two edges
        rst = 1'b1;
        drive(1'b0, 4'b0000, 4'b0000, 1'b0);
        tick(); tick();
        chk("rst_q0", 16'(if0.q), 16'h000a);
        chk("rst_q3", 16'(if3.q), 16'h000a);
        chk("rst_rise0", 16'(if0.q_rise), 16'h0);
        chk("rst_fall0", 16'(if0.q_fall), 16'h0);
        chk("rst_conf0", 16'(if0.conflict), 16'h0);
        chk("rst_cnt0", 16'(if0.conflict_cnt), 16'h0);
        chk("rst_sticky0", 16'(if0.err_sticky), 16'h0);

        // First update after release: pulses measured against RESET_VAL
        rst = 1'b0;
        drive(1'b1, 4'b0001, 4'b1000, 1'b0);
        tick();
        chk("basic_q0", 16'(if0.q), 16'h0003);
        chk("basic_q3", 16'(if3.q), 16'h0003);
        chk("basic_rise0", 16'(if0.q_rise), 16'h0001);
        chk("basic_fall0", 16'(if0.q_fall), 16'h0008);
        chk("basic_cnt0", 16'(if0.conflict_cnt), 16'h0);

        // Clear everything to 0
        drive(1'b1, 4'b0000, 4'b1111, 1'b0);
        tick();
        chk("clrall_q0", 16'(if0.q), 16'h0);
        chk("clrall_fall0", 16'(if0.q_fall), 16'h0003);
        chk("clrall_rise0", 16'(if0.q_rise), 16'h0);

        // Three conflict cycles on channel 0 in every mode
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, 4'b0001, 4'b0001, 1'b0);
            tick();
            chk("mode_q0", 16'(if0.q), 16'h0);
            chk("mode_q1", 16'(if1.q), 16'(q1_e[c]));
            chk("mode_rise1", 16'(if1.q_rise), 16'(r1_e[c]));
            chk("mode_q2", 16'(if2.q), 16'h0);
            chk("mode_q3", 16'(if3.q), 16'(q3_e[c]));
            chk("mode_rise3", 16'(if3.q_rise), 16'(r3_e[c]));
            chk("mode_fall3", 16'(if3.q_fall), 16'(f3_e[c]));
            chk("mode_conf0", 16'(if0.conflict), 16'h0001);
            chk("mode_conf2", 16'(if2.conflict), 16'h0001);
            chk("mode_cnt3", 16'(if3.conflict_cnt), 16'(c + 1));
            chk("mode_sticky0", 16'(if0.err_sticky), 16'h1);
        end
        chk("mode_cnt0", 16'(if0.conflict_cnt), 16'd3);
        chk("mode_cnt1", 16'(if1.conflict_cnt), 16'd3);
        chk("mode_cnt2", 16'(if2.conflict_cnt), 16'd3);

        // Enable gating
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 4'b1111, 4'b0000, 1'b0);
            tick();
            chk("gate_q0", 16'(if0.q), 16'h0);
            chk("gate_q1", 16'(if1.q), 16'h0001);
            chk("gate_q3", 16'(if3.q), 16'h0001);
            chk("gate_rise0", 16'(if0.q_rise), 16'h0);
            chk("gate_fall3", 16'(if3.q_fall), 16'h0);
            chk("gate_conf0", 16'(if0.conflict), 16'h0);
            chk("gate_cnt0", 16'(if0.conflict_cnt), 16'd3);
            chk("gate_sticky0", 16'(if0.err_sticky), 16'h1);
        end

        // Clear while disabled; q untouched
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        tick();
        chk("clr_cnt0", 16'(if0.conflict_cnt), 16'h0);
        chk("clr_sticky0", 16'(if0.err_sticky), 16'h0);
        chk("clr_cnts", 16'(ifs.conflict_cnt), 16'h0);
        chk("clr_q3", 16'(if3.q), 16'h0001);

        // Saturation of the 2-bit counter
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, 4'b0001, 4'b0001, 1'b0);
            tick();
            chk("sat_cnts", 16'(ifs.conflict_cnt), 16'(sat_e[c]));
            chk("sat_stickys", 16'(ifs.err_sticky), 16'h1);
            chk("sat_cnt0", 16'(if0.conflict_cnt), 16'(c + 1));
            chk("sat_q3", 16'(if3.q), 16'(tg_e[c]));
        end

        // Build cnt=2, then clear together with a conflict
        drive(1'b0, 4'b0000, 4'b0000, 1'b1);
        tick();
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        tick(); tick();
        chk("pre_cnt0", 16'(if0.conflict_cnt), 16'd2);
        drive(1'b1, 4'b0001, 4'b0001, 1'b1);
        tick();
        chk("clrc_cnt0", 16'(if0.conflict_cnt), 16'h0);
        chk("clrc_sticky0", 16'(if0.err_sticky), 16'h0);
        chk("clrc_conf0", 16'(if0.conflict), 16'h0001);
        chk("clrc_q3", 16'(if3.q), 16'h0001);
        chk("clrc_rise3", 16'(if3.q_rise), 16'h0001);
        drive(1'b1, 4'b0001, 4'b0001, 1'b0);
        tick();
        chk("after_cnt0", 16'(if0.conflict_cnt), 16'd1);
        chk("after_sticky0", 16'(if0.err_sticky), 16'h1);
        chk("after_q3", 16'(if3.q), 16'h0);
        tick();
        chk("pre_rst_q3", 16'(if3.q), 16'h0001);

        // Reset mid-toggle while q=1: no pulses, RESET_VAL reloaded
        rst = 1'b1;
        tick();
        chk("mrst_q3", 16'(if3.q), 16'h000a);
        chk("mrst_rise3", 16'(if3.q_rise), 16'h0);
        chk("mrst_fall3", 16'(if3.q_fall), 16'h0);
        chk("mrst_conf3", 16'(if3.conflict), 16'h0);
        chk("mrst_cnt3", 16'(if3.conflict_cnt), 16'h0);
        chk("mrst_sticky3", 16'(if3.err_sticky), 16'h0);
        rst = 1'b0;
        tick();
        chk("resume_q3", 16'(if3.q), 16'h000b);
        chk("resume_rise3", 16'(if3.q_rise), 16'h0001);
        chk("resume_cnt3", 16'(if3.conflict_cnt), 16'd1);
        tick();
        chk("resume2_q3", 16'(if3.q), 16'h000a);
        chk("resume2_fall3", 16'(if3.q_fall), 16'h0001);
        chk("resume2_cnt3", 16'(if3.conflict_cnt), 16'd2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
